// File: rtl/regfile_wr_arbiter_if.sv
// Write-port sharing bus: core writeback, debug/loader push port and the
// register file WE3/A3/WD3 port, plus debug FIFO occupancy.
interface regfile_wr_arbiter_if #(
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int DEPTH = 2
);
   localparam int PW = $clog2(DEPTH + 1);

   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wd;
   logic          core_stall;

   logic          dbg_valid;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wd;
   logic          dbg_ready;

   logic          rf_we;
   logic [AW-1:0] rf_a3;
   logic [DW-1:0] rf_wd;
   logic [PW-1:0] pending;

   modport slave (
      input  core_we, core_addr, core_wd, dbg_valid, dbg_addr, dbg_wd,
      output core_stall, dbg_ready, rf_we, rf_a3, rf_wd, pending
   );

   modport master (
      output core_we, core_addr, core_wd, dbg_valid, dbg_addr, dbg_wd,
      input  core_stall, dbg_ready, rf_we, rf_a3, rf_wd, pending
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register file write port between core writeback and a
// buffered debug port; debug drains into free slots or steals one core cycle.
module regfile_wr_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 8,
   parameter int AW       = 5,
   parameter int DW       = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_wr_arbiter_if.slave bus
);
   localparam int PTRW = $clog2(DEPTH);
   localparam int PW   = $clog2(DEPTH + 1);
   localparam int WCW  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      STEAL = 1'b1
   } state_t;

   state_t          state;
   logic [PTRW-1:0] rd_ptr;
   logic [PTRW-1:0] wr_ptr;
   logic [PW-1:0]   count;
   logic [WCW-1:0]  wait_cnt;

   logic [AW-1:0]   fifo_addr [DEPTH];
   logic [DW-1:0]   fifo_wd   [DEPTH];

   logic            empty;
   logic            push;
   logic            pop;
   logic            core_free;
   logic            blocked;
   logic [AW-1:0]   head_addr;
   logic [DW-1:0]   head_wd;

   logic            sel_we;
   logic [AW-1:0]   sel_a3;
   logic [DW-1:0]   sel_wd;

   assign empty     = (count == '0);
   assign head_addr = fifo_addr[rd_ptr];
   assign head_wd   = fifo_wd[rd_ptr];

   // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
   assign bus.dbg_ready = (count != PW'(DEPTH));
   assign push          = bus.dbg_valid && bus.dbg_ready;
   assign core_free     = !bus.core_we || (bus.core_addr == '0);
   assign pop           = !empty && ((state == STEAL) || core_free);
   assign blocked       = !empty && !core_free && (state == IDLE);

   assign bus.core_stall = (state == STEAL);
   assign bus.pending    = count;

   always_comb begin
      sel_we = 1'b0;
      sel_a3 = bus.core_addr;
      sel_wd = bus.core_wd;
      if (pop) begin
         sel_we = (head_addr != '0);
         sel_a3 = head_addr;
         sel_wd = head_wd;
      end else if (state == IDLE) begin
         sel_we = bus.core_we && (bus.core_addr != '0);
      end
   end

   // The core path is combinational, so the write enable is also gated by reset directly.
   assign bus.rf_we = rst_n && sel_we;
   assign bus.rf_a3 = sel_a3;
   assign bus.rf_wd = sel_wd;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.dbg_addr;
         fifo_wd[wr_ptr]   <= bus.dbg_wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
         case ({push, pop})
            2'b10:   count <= count + PW'(1);
            2'b01:   count <= count - PW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (blocked) begin
                  if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                     state    <= STEAL;
                     wait_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + WCW'(1);
                  end
               end else begin
                  wait_cnt <= '0;
               end
            end
            STEAL: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed, table-driven bench for regfile_wr_arbiter (DEPTH=2, MAX_WAIT=8),
// with hand-written sequences for reset and asynchronous reset during a steal.
module tb_regfile_wr_arbiter;
   logic clk;
   logic rst_n;

   regfile_wr_arbiter_if #(.AW(5), .DW(32), .DEPTH(2)) bus ();

   regfile_wr_arbiter #(.DEPTH(2), .MAX_WAIT(8), .AW(5), .DW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cwe;
      logic [4:0]  ca;
      logic [31:0] cwd;
      logic        dv;
      logic [4:0]  da;
      logic [31:0] dwd;
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        stall;
      logic        rdy;
      logic [1:0]  pend;
   } vec_t;

   vec_t rows [64];
   int   nrows;
   int   checks;
   int   failures;

   task automatic add(input logic cwe, input logic [4:0] ca, input logic [31:0] cwd,
                      input logic dv, input logic [4:0] da, input logic [31:0] dwd,
                      input logic we, input logic [4:0] a3, input logic [31:0] wd,
                      input logic stall, input logic rdy, input logic [1:0] pend);
      rows[nrows].cwe   = cwe;
      rows[nrows].ca    = ca;
      rows[nrows].cwd   = cwd;
      rows[nrows].dv    = dv;
      rows[nrows].da    = da;
      rows[nrows].dwd   = dwd;
      rows[nrows].we    = we;
      rows[nrows].a3    = a3;
      rows[nrows].wd    = wd;
      rows[nrows].stall = stall;
      rows[nrows].rdy   = rdy;
      rows[nrows].pend  = pend;
      nrows++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic cwe, input logic [4:0] ca, input logic [31:0] cwd,
                        input logic dv, input logic [4:0] da, input logic [31:0] dwd);
      bus.core_we   = cwe;
      bus.core_addr = ca;
      bus.core_wd   = cwd;
      bus.dbg_valid = dv;
      bus.dbg_addr  = da;
      bus.dbg_wd    = dwd;
   endtask

   initial begin
      int   n;
      logic found;
      checks   = 0;
      failures = 0;
      nrows    = 0;

      // Basic pass-through and debug drain into an idle slot
      add(1, 5, 32'hDEADBEEF, 0, 0, 0,       1, 5, 32'hDEADBEEF, 0, 1, 0);
      add(0, 0, 0,            1, 3, 32'h11,  0, 0, 0,            0, 1, 0);
      add(0, 0, 0,            0, 0, 0,       1, 3, 32'h11,       0, 1, 1);
      add(0, 0, 0,            0, 0, 0,       0, 0, 0,            0, 1, 0);
      // Two pushes under a busy core, full FIFO refuses, then two steals
      add(1, 7, 32'h70, 1, 9,  32'h99, 1, 7, 32'h70, 0, 1, 0);
      add(1, 7, 32'h71, 1, 10, 32'hAA, 1, 7, 32'h71, 0, 1, 1);
      add(1, 7, 32'h72, 1, 11, 32'hBB, 1, 7, 32'h72, 0, 0, 2);
      for (int k = 3; k <= 8; k++)
         add(1, 7, 32'h70 + k, 0, 0, 0, 1, 7, 32'h70 + k, 0, 0, 2);
      add(1, 7, 32'h79, 1, 12, 32'hCC, 1, 9, 32'h99, 1, 0, 2);
      for (int k = 0; k <= 7; k++)
         add(1, 7, 32'h80 + k, 0, 0, 0, 1, 7, 32'h80 + k, 0, 1, 1);
      add(1, 7, 32'h88, 0, 0, 0, 1, 10, 32'hAA, 1, 1, 1);
      add(1, 7, 32'h88, 0, 0, 0, 1, 7,  32'h88, 0, 1, 0);
      // Debug entry to x0 alongside core writes to x0
      add(1, 0, 32'h1, 1, 0, 32'h55, 0, 0, 0, 0, 1, 0);
      add(1, 0, 32'h2, 0, 0, 0,      0, 0, 0, 0, 1, 1);
      add(0, 0, 0,     0, 0, 0,      0, 0, 0, 0, 1, 0);
      // Push and pop in the same cycle; head data latched at push
      add(0, 0, 0, 1, 4, 32'h44,   0, 0, 0,      0, 1, 0);
      add(0, 0, 0, 1, 6, 32'h66,   1, 4, 32'h44, 0, 1, 1);
      add(0, 0, 0, 0, 6, 32'hFFFF, 1, 6, 32'h66, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0,        0, 0, 0,      0, 1, 0);

      // Reset state, including forced rf_we while the core requests a write
      rst_n = 1'b1;
      drive(1, 5, 32'h5, 0, 0, 0);
      #1 rst_n = 1'b0;
      #2;
      chk("reset_rf_we",   32'(bus.rf_we),      0);
      chk("reset_stall",   32'(bus.core_stall), 0);
      chk("reset_ready",   32'(bus.dbg_ready),  1);
      chk("reset_pending", 32'(bus.pending),    0);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < nrows; i++) begin
         drive(rows[i].cwe, rows[i].ca, rows[i].cwd, rows[i].dv, rows[i].da, rows[i].dwd);
         #1;
         chk($sformatf("row%0d_rf_we", i),   32'(bus.rf_we),      32'(rows[i].we));
         chk($sformatf("row%0d_stall", i),   32'(bus.core_stall), 32'(rows[i].stall));
         chk($sformatf("row%0d_ready", i),   32'(bus.dbg_ready),  32'(rows[i].rdy));
         chk($sformatf("row%0d_pending", i), 32'(bus.pending),    32'(rows[i].pend));
         if (rows[i].we) begin
            chk($sformatf("row%0d_rf_a3", i), 32'(bus.rf_a3), 32'(rows[i].a3));
            chk($sformatf("row%0d_rf_wd", i), bus.rf_wd,      rows[i].wd);
         end
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a steal cycle
      drive(1, 7, 32'h700, 1, 2, 32'h22);
      #1 chk("steal_push_ready", 32'(bus.dbg_ready), 1);
      @(negedge clk);
      bus.dbg_valid = 1'b0;
      found = 1'b0;
      n = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         #1;
         if (bus.core_stall) begin
            found = 1'b1;
         end else begin
            n++;
            @(negedge clk);
         end
      end
      chk("steal_seen", 32'(found), 1);
      chk("steal_wait_cycles", n, 8);
      chk("steal_rf_we", 32'(bus.rf_we), 1);
      chk("steal_rf_a3", 32'(bus.rf_a3), 2);
      chk("steal_rf_wd", bus.rf_wd, 32'h22);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_stall",   32'(bus.core_stall), 0);
      chk("async_rst_rf_we",   32'(bus.rf_we),      0);
      chk("async_rst_pending", 32'(bus.pending),    0);
      chk("async_rst_ready",   32'(bus.dbg_ready),  1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 7, 32'h77, 0, 0, 0);
      #1;
      chk("post_rst_rf_we", 32'(bus.rf_we),      1);
      chk("post_rst_rf_a3", 32'(bus.rf_a3),      7);
      chk("post_rst_rf_wd", bus.rf_wd,           32'h77);
      chk("post_rst_stall", 32'(bus.core_stall), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the register file's single write port (WE3/A3/WD3) between the core writeback path and a debug/loader port. The core writes whenever it needs to; debug writes are buffered in a small FIFO and drained into idle write slots. If debug writes starve, the block steals one core cycle by stalling the core. It sits between writeback, the debug interface and the register file write port.

Parameters:
DEPTH, 2, debug FIFO entries (power of 2, ≥2)
MAX_WAIT, 8, consecutive blocked cycles with FIFO non-empty before a steal cycle (≥1)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
core_we  in  1  core writeback request this cycle
core_addr  in  AW  core destination register
core_wd  in  DW  core writeback data
core_stall  out  1  core must hold its current instruction this cycle
dbg_valid  in  1  debug write request
dbg_addr  in  AW  debug destination register
dbg_wd  in  DW  debug write data
dbg_ready  out  1  FIFO can accept; push when dbg_valid && dbg_ready
rf_we  out  1  to register file WE3
rf_a3  out  AW  to register file A3
rf_wd  out  DW  to register file WD3
pending  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pending=0, wait_cnt=0, state=IDLE, core_stall=0, dbg_ready=1, rf_we forced 0.
- dbg_ready = (pending != DEPTH). It depends only on registered occupancy, so a push into a full FIFO is refused even if a pop occurs in the same cycle.
- A core slot is free when !core_we or core_addr==0.
- States: IDLE, STEAL.
- IDLE, FIFO non-empty, core slot free: pop the head and drive rf_we/rf_a3/rf_wd from it. wait_cnt clears.
- IDLE, FIFO non-empty, core slot busy: the core write passes through and wait_cnt increments. When wait_cnt==MAX_WAIT-1 and still blocked, the next state is STEAL.
- IDLE, FIFO empty: the core write passes through combinationally. rf_we = core_we && core_addr!=0. wait_cnt=0.
- STEAL, exactly one cycle: core_stall=1 (combinational from state), the head is popped and written, and the core write is suppressed. Next state is IDLE with wait_cnt=0. The core re-presents its write next cycle, so the core write lands after the debug write.
- Writes to x0 from either source are never driven to rf_we. A debug entry addressed to x0 is still popped and consumed.
- A push and a pop in the same cycle leave pending unchanged. Head data is latched at push, so the entry is unaffected by later dbg_* changes.
- The FIFO uses wrap-around read/write pointers of $clog2(DEPTH) bits. Occupancy is tracked separately to distinguish full from empty.
- Latency: a debug write accepted at cycle N reaches rf_we at cycle N+1 at the earliest. The core path has zero added latency except in STEAL cycles.
- Asserting rst_n low mid-operation discards all pending debug entries and drops core_stall immediately.

Test Plan:
- Reset, then core_we=1, addr=5, wd=0xDEADBEEF, FIFO empty -> same cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF, core_stall=0.
- Push debug (addr=3, wd=0x11) at cycle N with core_we=0 at N+1 -> at N+1 rf_we=1, rf_a3=3, rf_wd=0x11, pending returns to 0.
- Push 2 entries with core_we=1, addr=7 every cycle, MAX_WAIT=8 -> core writes pass for 8 cycles, then 1 cycle with core_stall=1 and rf_a3 = first debug addr, then core writes resume. The second entry steals again after 8 more cycles.
- Fill FIFO (pending=2) with core busy -> dbg_ready=0 and a third dbg_valid is not accepted. After one pop, dbg_ready=1.
- Debug entry to x0 alongside core_we=1 to x0 -> rf_we=0, entry consumed, pending decrements, no stall.
- Assert rst_n=0 during a STEAL cycle -> core_stall=0, rf_we=0, pending=0 immediately, without waiting for a clock edge.
